// File: rtl/debug_trace_buffer_pkg.sv
// rtl/debug_trace_buffer_pkg.sv - shared state encoding and trace entry layout helpers
// Entry layout is {ts, pc, data} with data in the least significant bits.
package debug_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } dtb_state_e;

    localparam int DATA_LSB = 0;

    function automatic int trace_entry_w(input int ts_w, input int pc_w, input int data_w);
        return ts_w + pc_w + data_w;
    endfunction

    function automatic int pc_lsb(input int data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int ts_lsb(input int pc_w, input int data_w);
        return DATA_LSB + data_w + pc_w;
    endfunction

endpackage

// File: rtl/debug_trace_buffer_if.sv
// rtl/debug_trace_buffer_if.sv - sampling, control and readout signals of the trace buffer
// master drives sampling/control and pops entries; slave is the trace buffer itself.
interface debug_trace_buffer_if
    import debug_trace_buffer_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 12
);
    localparam int ENTRY_W = trace_entry_w(TS_WIDTH, PC_WIDTH, DATA_WIDTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic                  enable;
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] debug_data;
    logic                  arm;
    logic                  stop;
    logic                  trig_en;
    logic [PC_WIDTH-1:0]   trig_pc;
    logic                  mode_all;
    logic                  wrap_en;
    logic                  rd_req;
    logic                  rd_valid;
    logic [ENTRY_W-1:0]    rd_data;
    logic [CNT_W-1:0]      count;
    logic                  triggered;
    logic                  done;
    logic                  overflow;

    modport master (
        output enable, pc, debug_data, arm, stop, trig_en, trig_pc, mode_all, wrap_en, rd_req,
        input  rd_valid, rd_data, count, triggered, done, overflow
    );

    modport slave (
        input  enable, pc, debug_data, arm, stop, trig_en, trig_pc, mode_all, wrap_en, rd_req,
        output rd_valid, rd_data, count, triggered, done, overflow
    );

endinterface

// File: rtl/debug_trace_buffer_trace_ram.sv
// rtl/debug_trace_buffer_trace_ram.sv - trace storage, one sync write port and one sync read port
// Storage carries no reset; read data appears one cycle after i_re.
module trace_ram
    import debug_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 28,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - triggered circular trace capture of {timestamp, pc, debug value}
// Capture FSM, pointer/count bookkeeping and oldest-first readout around trace_ram.
module debug_trace_buffer
    import debug_trace_buffer_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 12
) (
    input logic                 clk,
    input logic                 reset,
    debug_trace_buffer_if.slave bus
);

    localparam int ENTRY_W = trace_entry_w(TS_WIDTH, PC_WIDTH, DATA_WIDTH);
    localparam int SMP_W   = PC_WIDTH + DATA_WIDTH;
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int TS_LSB  = ts_lsb(PC_WIDTH, DATA_WIDTH);
    localparam int PC_LSB  = pc_lsb(DATA_WIDTH);

    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [TS_WIDTH-1:0] TS_MAX   = '1;

    dtb_state_e          r_state;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [TS_WIDTH-1:0] r_ts;
    logic                r_triggered;
    logic                r_overflow;
    logic                r_rd_valid;
    logic [SMP_W-1:0]    r_last;

    logic [SMP_W-1:0]    w_sample;
    logic                w_trig_hit;
    logic                w_cap_qual;
    logic                w_full;
    logic                w_we;
    logic                w_rd_fire;
    logic [TS_WIDTH-1:0] w_ts_next;
    logic [TS_WIDTH-1:0] w_wr_ts;
    logic [ENTRY_W-1:0]  w_wdata;
    logic [ENTRY_W-1:0]  w_ram_q;

    assign w_sample   = {bus.pc, bus.debug_data};
    assign w_trig_hit = bus.enable && (!bus.trig_en || (bus.pc == bus.trig_pc));
    assign w_cap_qual = bus.enable && (bus.mode_all || (w_sample != r_last));
    assign w_full     = (r_count == CNT_FULL);
    assign w_ts_next  = (r_ts == TS_MAX) ? r_ts : r_ts + 1'b1;
    assign w_rd_fire  = !reset && !bus.arm && (r_state == ST_DONE) && bus.rd_req
                        && (r_count != '0);

    // A full buffer only accepts a store when it may overwrite the oldest entry.
    always_comb begin
        w_we    = 1'b0;
        w_wr_ts = w_ts_next;
        if (!reset && !bus.arm) begin
            case (r_state)
                ST_ARMED: begin
                    if (w_trig_hit) begin
                        w_we    = 1'b1;
                        w_wr_ts = '0;
                    end
                end
                ST_CAPTURE: w_we = w_cap_qual && (!w_full || bus.wrap_en);
                default:    w_we = 1'b0;
            endcase
        end
    end

    assign w_wdata[TS_LSB +: TS_WIDTH]     = w_wr_ts;
    assign w_wdata[PC_LSB +: PC_WIDTH]     = bus.pc;
    assign w_wdata[DATA_LSB +: DATA_WIDTH] = bus.debug_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ts        <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_last      <= '0;
        end else if (bus.arm) begin
            r_state     <= ST_ARMED;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ts        <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_last      <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_last   <= w_sample;
                if (w_full) begin
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            case (r_state)
                ST_ARMED: begin
                    if (w_trig_hit) begin
                        r_triggered <= 1'b1;
                        r_ts        <= '0;
                        r_state     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.enable) begin
                        r_ts <= w_ts_next;
                    end
                    // Without wrap, the store into the last free slot ends capture on the same edge.
                    if (bus.stop || (!bus.wrap_en && (w_full || (w_we && r_count == CNT_LAST)))) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_fire),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_valid ? w_ram_q : '0;
    assign bus.count     = r_count;
    assign bus.triggered = r_triggered;
    assign bus.done      = (r_state == ST_DONE);
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb/tb_debug_trace_buffer.sv - directed bench with queue scoreboard for debug_trace_buffer
module tb_debug_trace_buffer;

    localparam int PC_W    = 8;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TS_W    = 12;
    localparam int ENTRY_W = TS_W + PC_W + DATA_W;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_CAP   = 2;
    localparam int S_DONE  = 3;

    logic clk;
    logic reset;

    debug_trace_buffer_if #(
        .PC_WIDTH(PC_W), .DATA_WIDTH(DATA_W), .DEPTH(DEPTH), .TS_WIDTH(TS_W)
    ) dif ();

    debug_trace_buffer #(
        .PC_WIDTH(PC_W), .DATA_WIDTH(DATA_W), .DEPTH(DEPTH), .TS_WIDTH(TS_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_asserts = 0;
    int n_fail    = 0;

    int                         m_state = S_IDLE;
    logic [TS_W-1:0]            m_ts    = '0;
    logic [PC_W+DATA_W-1:0]     m_last  = '0;
    bit                         m_trig  = 0;
    bit                         m_ovf   = 0;
    bit                         m_pend_v;
    logic [ENTRY_W-1:0]         m_pend;
    logic [ENTRY_W-1:0]         exp_q[$];
    logic [ENTRY_W-1:0]         got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int ts, input int pc, input int d);
        logic [ENTRY_W-1:0] e;
        e = {TS_W'(ts), PC_W'(pc), DATA_W'(d)};
        return 32'(e);
    endfunction

    function automatic logic [31:0] got_at(input int k);
        if (k < got.size()) return 32'(got[k]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic push_sample();
        exp_q.push_back({m_ts, dif.pc, dif.debug_data});
        m_last = {dif.pc, dif.debug_data};
    endtask

    // Advance the reference model with the inputs about to be sampled, clock once, then compare.
    task automatic tick();
        bit qual;
        m_pend_v = 0;
        if (reset) begin
            m_state = S_IDLE; exp_q.delete(); m_ts = '0; m_trig = 0; m_ovf = 0;
        end else if (dif.arm) begin
            m_state = S_ARMED; exp_q.delete(); m_ts = '0; m_trig = 0; m_ovf = 0; m_last = '0;
        end else begin
            case (m_state)
                S_ARMED: begin
                    if (dif.enable && (!dif.trig_en || dif.pc == dif.trig_pc)) begin
                        m_ts = '0; push_sample(); m_trig = 1; m_state = S_CAP;
                    end
                end
                S_CAP: begin
                    if (dif.enable) begin
                        if (m_ts != '1) m_ts = m_ts + 1'b1;
                        qual = dif.mode_all || ({dif.pc, dif.debug_data} != m_last);
                        if (qual) begin
                            if (exp_q.size() < DEPTH) push_sample();
                            else if (dif.wrap_en) begin
                                void'(exp_q.pop_front()); m_ovf = 1; push_sample();
                            end
                        end
                    end
                    if (dif.stop || (!dif.wrap_en && exp_q.size() == DEPTH)) m_state = S_DONE;
                end
                S_DONE: begin
                    if (dif.rd_req && exp_q.size() > 0) begin
                        m_pend = exp_q.pop_front(); m_pend_v = 1;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        chk("count", 32'(dif.count), 32'(exp_q.size()));
        chk("done", 32'(dif.done), 32'(m_state == S_DONE));
        chk("triggered", 32'(dif.triggered), 32'(m_trig));
        chk("overflow", 32'(dif.overflow), 32'(m_ovf));
        chk("rd_valid", 32'(dif.rd_valid), 32'(m_pend_v));
        if (m_pend_v) chk("rd_data", 32'(dif.rd_data), 32'(m_pend));
    endtask

    task automatic read_for(input int cycles);
        got.delete();
        dif.rd_req = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (dif.rd_valid) got.push_back(dif.rd_data);
        end
        dif.rd_req = 1'b0;
    endtask

    task automatic do_arm();
        dif.arm = 1'b1;
        tick();
        dif.arm = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        dif.enable = 0; dif.pc = '0; dif.debug_data = '0; dif.arm = 0; dif.stop = 0;
        dif.trig_en = 0; dif.trig_pc = '0; dif.mode_all = 0; dif.wrap_en = 0; dif.rd_req = 0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_rd_data", 32'(dif.rd_data), 32'h0);
        chk("reset_count", 32'(dif.count), 32'h0);

        // PC-match trigger, stop after pc=8
        do_arm();
        dif.trig_en = 1; dif.trig_pc = 8'd5; dif.mode_all = 1; dif.enable = 1;
        for (int i = 0; i <= 8; i++) begin
            dif.pc = PC_W'(i); dif.debug_data = DATA_W'(8'h10 + i);
            dif.stop = (i == 8);
            tick();
            if (i == 4) chk("trig_not_yet", 32'(dif.triggered), 32'h0);
            if (i == 5) chk("trig_rise", 32'(dif.triggered), 32'h1);
        end
        dif.stop = 0; dif.pc = 8'd9; dif.debug_data = 8'h19;
        tick();
        chk("trig_count", 32'(dif.count), 32'd4);
        read_for(6);
        chk("trig_pulses", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("trig_entry", got_at(k), ent(k, 5 + k, 8'h15 + k));

        // change-only sampling at fixed pc
        do_arm();
        dif.trig_en = 0; dif.mode_all = 0; dif.pc = 8'd2; dif.debug_data = 8'h3C;
        for (int i = 0; i < 6; i++) tick();
        dif.debug_data = 8'h3D;
        tick();
        dif.stop = 1;
        tick();
        dif.stop = 0;
        chk("chg_count", 32'(dif.count), 32'd2);
        read_for(4);
        chk("chg_pulses", 32'(got.size()), 32'd2);
        chk("chg_entry0", got_at(0), ent(0, 2, 8'h3C));
        chk("chg_entry1", got_at(1), ent(6, 2, 8'h3D));

        // stop on full, then rd_req held for 18 cycles
        do_arm();
        dif.mode_all = 1; dif.wrap_en = 0;
        for (int i = 0; i < DEPTH; i++) begin
            dif.pc = PC_W'(i); dif.debug_data = DATA_W'(i);
            tick();
            if (i == DEPTH - 2) chk("full_not_done", 32'(dif.done), 32'h0);
            if (i == DEPTH - 1) chk("full_done", 32'(dif.done), 32'h1);
        end
        chk("full_count", 32'(dif.count), 32'd16);
        chk("full_overflow", 32'(dif.overflow), 32'h0);
        read_for(18);
        chk("full_pulses", 32'(got.size()), 32'd16);
        for (int k = 0; k < DEPTH; k++) chk("full_entry", got_at(k), ent(k, k, k));
        chk("full_still_done", 32'(dif.done), 32'h1);

        // wrap with 20 samples; rd_req during capture must not pop
        do_arm();
        dif.wrap_en = 1;
        for (int i = 0; i < 20; i++) begin
            dif.pc = PC_W'(i); dif.debug_data = DATA_W'(8'h40 + i);
            dif.rd_req = (i < 3);
            tick();
            if (i == 2) chk("cap_no_rd_valid", 32'(dif.rd_valid), 32'h0);
        end
        dif.rd_req = 0; dif.enable = 0; dif.stop = 1;
        tick();
        dif.stop = 0;
        chk("wrap_overflow", 32'(dif.overflow), 32'h1);
        chk("wrap_count", 32'(dif.count), 32'd16);
        read_for(18);
        chk("wrap_pulses", 32'(got.size()), 32'd16);
        chk("wrap_first", got_at(0), ent(4, 4, 8'h44));
        chk("wrap_last", got_at(15), ent(19, 19, 8'h53));

        // arm during readout
        do_arm();
        dif.enable = 1; dif.wrap_en = 0;
        for (int i = 0; i < 4; i++) begin
            dif.pc = PC_W'(8'h80 + i); dif.stop = (i == 3);
            tick();
        end
        dif.stop = 0; dif.enable = 0; dif.rd_req = 1;
        tick();
        tick();
        chk("pre_arm_count", 32'(dif.count), 32'd2);
        dif.arm = 1;
        tick();
        dif.arm = 0; dif.rd_req = 0;
        chk("arm_rd_count", 32'(dif.count), 32'd0);
        chk("arm_rd_done", 32'(dif.done), 32'h0);
        tick();

        // reset mid-capture
        dif.enable = 1; dif.trig_en = 0;
        for (int i = 0; i < 3; i++) begin
            dif.pc = PC_W'(8'hA0 + i);
            tick();
        end
        reset = 1;
        tick();
        reset = 0;
        chk("rst_done", 32'(dif.done), 32'h0);
        chk("rst_triggered", 32'(dif.triggered), 32'h0);
        chk("rst_count", 32'(dif.count), 32'd0);
        chk("rst_rd_valid", 32'(dif.rd_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            dif.pc = PC_W'(8'hB0 + i);
            tick();
        end
        chk("rst_no_store", 32'(dif.count), 32'd0);
        do_arm();
        tick();
        chk("rearm_store", 32'(dif.count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Parametrised on-chip trace capture unit for microcontroller_top; replaces bench-only $monitor of PC and debug output with synthesizable logic.
- Samples {timestamp, PC, debug value} into a circular RAM after an optional PC-match trigger.
- Captures on value change or every cycle, stops on full or wraps.
- Frozen trace is read out oldest-first through a request/valid handshake.

Parameters:
- PC_WIDTH, 8, width of sampled program address.
- DATA_WIDTH, 8, width of sampled debug value (matches operand_size).
- DEPTH, 16, trace entries; power of two, >= 2.
- TS_WIDTH, 12, timestamp width; counts cycles since trigger.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  core enable; no sampling or timestamp advance when low
- pc  in  PC_WIDTH  current program address
- debug_data  in  DATA_WIDTH  current debug output
- arm  in  1  pulse; clear and arm (any state)
- stop  in  1  pulse; end capture (CAPTURE only)
- trig_en  in  1  1 = wait for pc==trig_pc; 0 = trigger immediately
- trig_pc  in  PC_WIDTH  trigger address
- mode_all  in  1  1 = sample every enabled cycle; 0 = only when {pc,debug_data} differs from last stored entry
- wrap_en  in  1  1 = overwrite oldest when full; 0 = stop when full
- rd_req  in  1  pop oldest entry (DONE only)
- rd_valid  out  1  rd_data valid, one-cycle pulse
- rd_data  out  TS_WIDTH+PC_WIDTH+DATA_WIDTH  {ts, pc, data}, MSB first
- count  out  clog2(DEPTH)+1  stored entries
- triggered  out  1  trigger seen since last arm
- done  out  1  state==DONE
- overflow  out  1  sticky; an entry was overwritten

Behaviour:
- Reset: state IDLE; all pointers, count, ts, outputs 0; rd_data 0.
- States IDLE, ARMED, CAPTURE, DONE. arm in any state -> ARMED next cycle; clears pointers, count, ts, triggered, overflow; arm wins over every other input.
- ARMED, on an enabled cycle with (trig_en==0 or pc==trig_pc): that cycle's sample is stored as entry 0 with ts=0, triggered=1, -> CAPTURE. enable low: hold.
- CAPTURE, per enabled cycle: ts increments, saturating at all-ones. Sample stored if mode_all=1 or {pc,debug_data} != last stored.
- Store when count==DEPTH:
  - wrap_en=1: overwrite oldest, advance read pointer, overflow=1, count stays DEPTH.
  - wrap_en=0: the store filling the last slot moves state to DONE the same edge; no further stores.
- stop in CAPTURE: a sample qualifying that cycle is still stored; -> DONE. stop outside CAPTURE is ignored.
- DONE, read side:
  - rd_req with count>0 -> rd_valid=1 and rd_data=oldest entry on the next cycle; read pointer advances and count decrements.
  - rd_req with count==0 -> ignored; rd_valid stays 0.
  - Back-to-back rd_req every cycle is supported at one entry per cycle.
  - rd_req outside DONE is ignored.
- Pointers wrap modulo DEPTH. Timestamps are never reset by wrap.
- done=1 only in DONE. After the last pop the state stays in DONE until arm.
- reset mid-capture or mid-readout: immediate return to IDLE; RAM contents don't care.

Decomposition:
- Shared package/params include:
  - state encodings (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
  - TRACE_ENTRY_W macro = TS_WIDTH+PC_WIDTH+DATA_WIDTH
  - field-offset constants for ts/pc/data
- One sub-module, trace_ram: DEPTH x TRACE_ENTRY_W, one synchronous write port, one synchronous read port (1-cycle latency), no reset on storage.

Test Plan:
- Trigger: trig_en=1, trig_pc=5, mode_all=1, PC steps 0..9 -> entry0 {ts=0, pc=5}, triggered rises on the cycle after pc==5; stop after pc=8 -> readout pcs 5,6,7,8 with ts 0,1,2,3, count=4.
- Change-only: mode_all=0, trig_en=0, debug_data held 0x3C for 6 cycles at fixed pc=2, then 0x3D -> exactly 2 entries (0x3C ts=0, 0x3D ts=6).
- Stop on full: DEPTH=16, wrap_en=0, mode_all=1 -> done asserts on the edge storing the 16th sample; count=16; overflow=0; readout ts 0..15.
- Wrap: wrap_en=1, 20 samples then stop -> overflow=1, count=16, first popped ts=4, last ts=19.
- Handshake and edges:
  - rd_req held 18 cycles in DONE with 16 entries -> 16 rd_valid pulses, then none.
  - rd_req in CAPTURE -> no rd_valid.
  - arm during readout -> ARMED, count=0.
- Reset: reset asserted for 1 cycle mid-CAPTURE -> next cycle done=0, triggered=0, count=0, rd_valid=0; no stores until re-armed.
